int_issue_queue: RTL and testbench
==================================

Name: int_issue_queue

Overview:
- Integer reservation station directly downstream of the dispatch unit.
- Accepts one integer-class op per cycle when dispatch asserts int_queue_en, holding renamed source operands as values or tags.
- Snoops the common data bus (CDB) to wake up waiting operands.
- Issues the oldest ready op to the integer ALU through a valid/ready handshake.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2).
- TAG_W, 6, width of a producer tag on the CDB and in the register status table.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (branch/jump redirect); synchronous.
- int_queue_en  in  1  dispatch enqueue strobe.
- disp_imm  in  1  op uses immediate as operand 2; rs2 ignored.
- disp_pc  in  32  PC of dispatched op.
- opcode  in  7  RISC-V opcode.
- funct3  in  3  RISC-V funct3.
- funct7  in  7  RISC-V funct7.
- disp_imm_val  in  32  sign-extended immediate.
- rs1_valid  in  1  rs1_data holds the value (else wait on rs1_tag).
- rs1_tag  in  TAG_W  producer tag for rs1.
- rs1_data  in  32  rs1 value.
- rs2_valid  in  1  as rs1_valid, for operand 2.
- rs2_tag  in  TAG_W  as rs1_tag, for operand 2.
- rs2_data  in  32  as rs1_data, for operand 2.
- rd_tag  in  TAG_W  destination tag assigned by dispatch.
- int_queue_full  out  1  no free entry; dispatch must not enqueue.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  32  broadcast value.
- iss_valid  out  1  issue request to ALU.
- iss_ready  in  1  ALU accepts this cycle.
- iss_op1  out  32  operand 1 of issued op.
- iss_op2  out  32  operand 2 of issued op.
- iss_pc  out  32  PC of issued op.
- iss_opcode  out  7  opcode of issued op.
- iss_funct3  out  3  funct3 of issued op.
- iss_funct7  out  7  funct7 of issued op.
- iss_rd_tag  out  TAG_W  destination tag of issued op.

Behaviour:
- Storage: collapsing queue, entry 0 oldest. Per entry: valid, op fields, pc, two operands each {rdy, tag, data}; rs2 stored rdy with data=disp_imm_val when disp_imm.
- Reset or flush: all entry valid bits cleared next edge. Outputs after reset: iss_valid=0, int_queue_full=0, iss_* data 0 (don't-care when iss_valid=0). Flush overrides enqueue, issue and wakeup in the same cycle.
- Enqueue: int_queue_en && !int_queue_full writes the first free slot, i.e. index count minus one if an issue pops this cycle, else index count.
- Enqueue while full is ignored, with state unchanged; the bench flags it as a protocol error.
- Wakeup: each stored non-ready operand whose tag equals cdb_tag with cdb_valid=1 captures cdb_data and sets rdy at the edge.
- Same-cycle bypass: an operand being enqueued with valid=0 and a tag matching a live CDB broadcast is written ready with cdb_data.
- Ready entry: valid, op1 rdy and op2 rdy.
- Issue is combinational from registered state:
  - iss_valid = any ready entry.
  - Outputs come from the lowest-index ready entry.
  - Wakeup in cycle N makes the entry issuable in cycle N+1.
  - An enqueued entry is issuable no earlier than the next cycle.
- Pop: on iss_valid && iss_ready the selected entry is removed and younger entries shift down one slot, preserving age order. Wakeup and enqueue apply to post-shift positions.
- iss_valid held with iss_ready=0: state is stable except wakeups; the selected entry may change only to an older entry that became ready.
- int_queue_full = (count == DEPTH), registered-count based. Dispatch cannot enqueue into a slot freed by a same-cycle pop.
- Count: 0..DEPTH; next = count + enq - pop.

Decomposition:
- Shared package: TAG_W default, iq_entry_t struct (op fields, pc, two operand structs), operand_t {rdy, tag, data}.
- One sub-module, iq_operand_slot: holds one operand with CDB wakeup compare. Instantiated 2*DEPTH times.

Test Plan:
- Reset, then enqueue addi (disp_imm=1, imm=5, rs1_valid=1, rs1_data=10) -> next cycle iss_valid=1, iss_op1=10, iss_op2=5; iss_ready=1 pops; count back to 0.
- Enqueue op A with rs1 waiting on tag 3; CDB tag 3 data 0x55 two cycles later -> iss_valid rises the cycle after broadcast with iss_op1=0x55.
- Enqueue A (waiting tag 7), then B (ready); B issues first; CDB tag 7 -> A issues; iss_rd_tag order B then A.
- Fill 4 entries -> int_queue_full=1; issue one with iss_ready=1 -> full drops next cycle; enqueue then succeeds; age order kept.
- Enqueue with rs2_tag=9 while CDB broadcasts tag 9 data 0xABCD in the same cycle -> entry ready immediately, issues next cycle with iss_op2=0xABCD.
- Three entries valid, assert flush together with int_queue_en -> next cycle count=0, iss_valid=0, int_queue_full=0.

Source files
------------

// File: rtl/int_issue_queue_pkg.sv
// Shared types for the integer issue queue: operand and entry layouts plus the default tag width.
package int_issue_queue_pkg;

    localparam int IQ_TAG_W = 6;

    typedef struct packed {
        logic                rdy;
        logic [IQ_TAG_W-1:0] tag;
        logic [31:0]         data;
    } operand_t;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [31:0]         pc;
        logic [IQ_TAG_W-1:0] rd_tag;
        operand_t            op1;
        operand_t            op2;
    } iq_entry_t;

endpackage

// File: rtl/int_issue_queue_operand_slot.sv
// One stored source operand: loads from dispatch or from the younger neighbour on a collapse,
// then snoops the CDB so a matching broadcast (including one in the load cycle) marks it ready.
module iq_operand_slot
    import int_issue_queue_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  operand_t            load_val,
    input  logic                shift,
    input  operand_t            shift_val,
    input  logic                cdb_valid,
    input  logic [IQ_TAG_W-1:0] cdb_tag,
    input  logic [31:0]         cdb_data,
    output operand_t            q
);

    operand_t src;
    operand_t nxt;

    always_comb begin
        src = q;
        if (load) begin
            src = load_val;
        end else if (shift) begin
            src = shift_val;
        end
        nxt = src;
        // Wakeup applies after the load/shift mux, which gives the same-cycle bypass for free
        if (!src.rdy && cdb_valid && (src.tag == cdb_tag)) begin
            nxt.rdy  = 1'b1;
            nxt.data = cdb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/int_issue_queue.sv
// Integer reservation station: collapsing age-ordered queue, CDB wakeup, oldest-ready issue.
// TAG_W must match IQ_TAG_W, which sizes the tag fields of the shared structs.
module int_issue_queue
    import int_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = IQ_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             int_queue_en,
    input  logic             disp_imm,
    input  logic [31:0]      disp_pc,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      disp_imm_val,
    input  logic             rs1_valid,
    input  logic [TAG_W-1:0] rs1_tag,
    input  logic [31:0]      rs1_data,
    input  logic             rs2_valid,
    input  logic [TAG_W-1:0] rs2_tag,
    input  logic [31:0]      rs2_data,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             int_queue_full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [31:0]      iss_op1,
    output logic [31:0]      iss_op2,
    output logic [31:0]      iss_pc,
    output logic [6:0]       iss_opcode,
    output logic [2:0]       iss_funct3,
    output logic [6:0]       iss_funct7,
    output logic [TAG_W-1:0] iss_rd_tag
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [CW-1:0]    count;
    logic [CW-1:0]    enq_idx;
    logic [IW-1:0]    sel;
    logic             enq;
    logic             pop;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] load_vec;
    logic [DEPTH-1:0] shift_vec;

    operand_t         op1_q    [DEPTH];
    operand_t         op2_q    [DEPTH];
    logic [6:0]       opcode_q [DEPTH];
    logic [2:0]       funct3_q [DEPTH];
    logic [6:0]       funct7_q [DEPTH];
    logic [31:0]      pc_q     [DEPTH];
    logic [TAG_W-1:0] rd_q     [DEPTH];

    iq_entry_t        disp_entry;

    always_comb begin
        disp_entry.opcode = opcode;
        disp_entry.funct3 = funct3;
        disp_entry.funct7 = funct7;
        disp_entry.pc     = disp_pc;
        disp_entry.rd_tag = rd_tag;
        disp_entry.op1    = '{rdy: rs1_valid, tag: rs1_tag, data: rs1_data};
        if (disp_imm) begin
            disp_entry.op2 = '{rdy: 1'b1, tag: '0, data: disp_imm_val};
        end else begin
            disp_entry.op2 = '{rdy: rs2_valid, tag: rs2_tag, data: rs2_data};
        end
    end

    // Lowest index is oldest, so the first ready entry from the bottom wins
    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel = IW'(i);
            end
        end
    end

    assign iss_valid      = |ready;
    assign pop            = iss_valid && iss_ready;
    assign int_queue_full = (count == CW'(DEPTH));
    assign enq            = int_queue_en && !int_queue_full;
    assign enq_idx        = count - {{(CW-1){1'b0}}, pop};

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam int NXT = (i == DEPTH - 1) ? i : i + 1;

        assign ready[i]     = (CW'(i) < count) && op1_q[i].rdy && op2_q[i].rdy;
        assign load_vec[i]  = enq && (enq_idx == CW'(i));
        assign shift_vec[i] = pop && (IW'(i) >= sel);

        iq_operand_slot u_op1 (
            .clk       (clk),
            .rst       (rst),
            .load      (load_vec[i]),
            .load_val  (disp_entry.op1),
            .shift     (shift_vec[i]),
            .shift_val (op1_q[NXT]),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .q         (op1_q[i])
        );

        iq_operand_slot u_op2 (
            .clk       (clk),
            .rst       (rst),
            .load      (load_vec[i]),
            .load_val  (disp_entry.op2),
            .shift     (shift_vec[i]),
            .shift_val (op2_q[NXT]),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .q         (op2_q[i])
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                opcode_q[i] <= '0;
                funct3_q[i] <= '0;
                funct7_q[i] <= '0;
                pc_q[i]     <= '0;
                rd_q[i]     <= '0;
            end else if (load_vec[i]) begin
                opcode_q[i] <= disp_entry.opcode;
                funct3_q[i] <= disp_entry.funct3;
                funct7_q[i] <= disp_entry.funct7;
                pc_q[i]     <= disp_entry.pc;
                rd_q[i]     <= disp_entry.rd_tag;
            end else if (shift_vec[i]) begin
                opcode_q[i] <= opcode_q[NXT];
                funct3_q[i] <= funct3_q[NXT];
                funct7_q[i] <= funct7_q[NXT];
                pc_q[i]     <= pc_q[NXT];
                rd_q[i]     <= rd_q[NXT];
            end
        end
    end

    // Entries 0..count-1 are live; flush simply empties the queue and overrides everything else
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else if (enq && !pop) begin
            count <= count + 1'b1;
        end else if (!enq && pop) begin
            count <= count - 1'b1;
        end
    end

    always_comb begin
        iss_op1    = '0;
        iss_op2    = '0;
        iss_pc     = '0;
        iss_opcode = '0;
        iss_funct3 = '0;
        iss_funct7 = '0;
        iss_rd_tag = '0;
        if (iss_valid) begin
            iss_op1    = op1_q[sel].data;
            iss_op2    = op2_q[sel].data;
            iss_pc     = pc_q[sel];
            iss_opcode = opcode_q[sel];
            iss_funct3 = funct3_q[sel];
            iss_funct7 = funct7_q[sel];
            iss_rd_tag = rd_q[sel];
        end
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: inputs change and outputs are checked on the falling edge.
module tb_int_issue_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        int_queue_en = 1'b0;
    logic        disp_imm = 1'b0;
    logic [31:0] disp_pc = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] disp_imm_val = '0;
    logic        rs1_valid = 1'b0;
    logic [5:0]  rs1_tag = '0;
    logic [31:0] rs1_data = '0;
    logic        rs2_valid = 1'b0;
    logic [5:0]  rs2_tag = '0;
    logic [31:0] rs2_data = '0;
    logic [5:0]  rd_tag = '0;
    logic        int_queue_full;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        iss_valid;
    logic        iss_ready = 1'b0;
    logic [31:0] iss_op1;
    logic [31:0] iss_op2;
    logic [31:0] iss_pc;
    logic [6:0]  iss_opcode;
    logic [2:0]  iss_funct3;
    logic [6:0]  iss_funct7;
    logic [5:0]  iss_rd_tag;

    int vectors = 0;
    int miscompares = 0;

    int_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .int_queue_en   (int_queue_en),
        .disp_imm       (disp_imm),
        .disp_pc        (disp_pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .disp_imm_val   (disp_imm_val),
        .rs1_valid      (rs1_valid),
        .rs1_tag        (rs1_tag),
        .rs1_data       (rs1_data),
        .rs2_valid      (rs2_valid),
        .rs2_tag        (rs2_tag),
        .rs2_data       (rs2_data),
        .rd_tag         (rd_tag),
        .int_queue_full (int_queue_full),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .iss_valid      (iss_valid),
        .iss_ready      (iss_ready),
        .iss_op1        (iss_op1),
        .iss_op2        (iss_op2),
        .iss_pc         (iss_pc),
        .iss_opcode     (iss_opcode),
        .iss_funct3     (iss_funct3),
        .iss_funct7     (iss_funct7),
        .iss_rd_tag     (iss_rd_tag)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic imm, input logic [31:0] imm_val,
                                  input logic r1v, input logic [5:0] r1t, input logic [31:0] r1d,
                                  input logic r2v, input logic [5:0] r2t, input logic [31:0] r2d,
                                  input logic [5:0] rd, input logic [31:0] pc);
        int_queue_en = 1'b1;
        disp_imm     = imm;
        disp_imm_val = imm_val;
        rs1_valid    = r1v;
        rs1_tag      = r1t;
        rs1_data     = r1d;
        rs2_valid    = r2v;
        rs2_tag      = r2t;
        rs2_data     = r2d;
        rd_tag       = rd;
        disp_pc      = pc;
        opcode       = imm ? 7'h13 : 7'h33;
        funct3       = rd[2:0];
        funct7       = imm ? 7'h00 : 7'h20;
    endtask

    task automatic step();
        @(negedge clk);
        int_queue_en = 1'b0;
        cdb_valid    = 1'b0;
        iss_ready    = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic send_cdb(input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] order [3];

        step();
        step();
        rst = 1'b0;
        check_output("reset_iss_valid", iss_valid, 0);
        check_output("reset_full", int_queue_full, 0);
        check_output("reset_op1", iss_op1, 0);
        check_output("reset_rd_tag", iss_rd_tag, 0);

        // addi: rs1 ready = 10, immediate 5
        apply_stimulus(1'b1, 32'd5, 1'b1, 6'd0, 32'd10, 1'b0, 6'd0, 32'd0, 6'd1, 32'h100);
        step();
        check_output("addi_valid", iss_valid, 1);
        check_output("addi_op1", iss_op1, 10);
        check_output("addi_op2", iss_op2, 5);
        check_output("addi_pc", iss_pc, 32'h100);
        check_output("addi_opcode", iss_opcode, 7'h13);
        check_output("addi_rd", iss_rd_tag, 1);
        iss_ready = 1'b1;
        step();
        check_output("addi_popped", iss_valid, 0);
        check_output("addi_not_full", int_queue_full, 0);

        // rs1 waits on tag 3, a wrong tag first, then tag 3
        apply_stimulus(1'b0, 32'd0, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'h22, 6'd2, 32'h104);
        step();
        check_output("wait_not_ready", iss_valid, 0);
        send_cdb(6'd4, 32'h99);
        step();
        check_output("wrong_tag_no_wake", iss_valid, 0);
        send_cdb(6'd3, 32'h55);
        check_output("wake_same_cycle_not_yet", iss_valid, 0);
        step();
        check_output("wake_valid", iss_valid, 1);
        check_output("wake_op1", iss_op1, 32'h55);
        check_output("wake_op2", iss_op2, 32'h22);
        check_output("wake_rd", iss_rd_tag, 2);
        iss_ready = 1'b1;
        step();
        check_output("wake_popped", iss_valid, 0);

        // A waits on tag 7, younger B ready: B issues first
        apply_stimulus(1'b0, 32'd0, 1'b0, 6'd7, 32'd0, 1'b1, 6'd0, 32'h1, 6'd10, 32'h200);
        step();
        apply_stimulus(1'b0, 32'd0, 1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h12, 6'd11, 32'h204);
        step();
        check_output("ooo_first_valid", iss_valid, 1);
        check_output("ooo_first_rd", iss_rd_tag, 11);
        check_output("ooo_first_op1", iss_op1, 32'h11);
        iss_ready = 1'b1;
        step();
        check_output("ooo_a_waiting", iss_valid, 0);
        send_cdb(6'd7, 32'h77);
        step();
        check_output("ooo_second_rd", iss_rd_tag, 10);
        check_output("ooo_second_op1", iss_op1, 32'h77);
        check_output("ooo_second_pc", iss_pc, 32'h200);
        iss_ready = 1'b1;
        step();
        check_output("ooo_empty", iss_valid, 0);

        // Fill four ready entries, rd 20..23, op1 = rd
        for (int k = 0; k < 4; k++) begin
            check_output("fill_not_full", int_queue_full, 0);
            apply_stimulus(1'b0, 32'd0, 1'b1, 6'd0, 32'(20 + k), 1'b1, 6'd0, 32'd0, 6'(20 + k), 32'(32'h300 + 4 * k));
            step();
        end
        check_output("fill_full", int_queue_full, 1);
        check_output("fill_head_rd", iss_rd_tag, 20);
        $display("[TB] note: deliberate enqueue while full (protocol error, must be ignored)");
        apply_stimulus(1'b0, 32'd0, 1'b1, 6'd0, 32'd30, 1'b1, 6'd0, 32'd0, 6'd30, 32'h3F0);
        step();
        check_output("full_ignore_full", int_queue_full, 1);
        check_output("full_ignore_head", iss_rd_tag, 20);
        // Pop while full: a same-cycle enqueue is still refused
        iss_ready = 1'b1;
        apply_stimulus(1'b0, 32'd0, 1'b1, 6'd0, 32'd31, 1'b1, 6'd0, 32'd0, 6'd31, 32'h3F4);
        step();
        check_output("pop_full_drops", int_queue_full, 0);
        check_output("pop_full_head", iss_rd_tag, 21);
        apply_stimulus(1'b0, 32'd0, 1'b1, 6'd0, 32'd24, 1'b1, 6'd0, 32'd0, 6'd24, 32'h310);
        step();
        check_output("refill_full", int_queue_full, 1);
        check_output("refill_head", iss_rd_tag, 21);
        iss_ready = 1'b1;
        step();
        check_output("drain1_head", iss_rd_tag, 22);
        check_output("drain1_full", int_queue_full, 0);
        // Pop and enqueue together: new entry lands at count-1
        iss_ready = 1'b1;
        apply_stimulus(1'b0, 32'd0, 1'b1, 6'd0, 32'd25, 1'b1, 6'd0, 32'd0, 6'd25, 32'h314);
        step();
        check_output("popenq_full", int_queue_full, 0);
        order[0] = 6'd23;
        order[1] = 6'd24;
        order[2] = 6'd25;
        for (int k = 0; k < 3; k++) begin
            check_output("drain_valid", iss_valid, 1);
            check_output("drain_rd", iss_rd_tag, order[k]);
            check_output("drain_op1", iss_op1, 32'(order[k]));
            iss_ready = 1'b1;
            step();
        end
        check_output("drain_empty", iss_valid, 0);

        // Same-cycle CDB bypass on rs2
        apply_stimulus(1'b0, 32'd0, 1'b1, 6'd0, 32'h1, 1'b0, 6'd9, 32'd0, 6'd40, 32'h400);
        send_cdb(6'd9, 32'hABCD);
        step();
        check_output("bypass_valid", iss_valid, 1);
        check_output("bypass_op2", iss_op2, 32'hABCD);
        check_output("bypass_rd", iss_rd_tag, 40);
        iss_ready = 1'b1;
        step();
        check_output("bypass_popped", iss_valid, 0);

        // Three entries, then flush together with enqueue
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 32'd0, 1'b1, 6'd0, 32'(50 + k), 1'b1, 6'd0, 32'd0, 6'(50 + k), 32'h500);
            step();
        end
        check_output("preflush_valid", iss_valid, 1);
        flush = 1'b1;
        apply_stimulus(1'b0, 32'd0, 1'b1, 6'd0, 32'd53, 1'b1, 6'd0, 32'd0, 6'd53, 32'h50C);
        step();
        check_output("flush_valid", iss_valid, 0);
        check_output("flush_full", int_queue_full, 0);
        // Count must be zero: full only after four fresh enqueues, head is the first of them
        for (int k = 0; k < 4; k++) begin
            check_output("postflush_not_full", int_queue_full, 0);
            apply_stimulus(1'b0, 32'd0, 1'b1, 6'd0, 32'(60 + k), 1'b1, 6'd0, 32'd0, 6'(60 + k), 32'h600);
            step();
        end
        check_output("postflush_full", int_queue_full, 1);
        check_output("postflush_head", iss_rd_tag, 60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
